// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan controller: state encoding,
// channel geometry and enabled-channel search.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } next_ch_t;

  // Next enabled channel strictly above cur, ascending order.
  function automatic next_ch_t next_enabled(input logic [NUM_CH-1:0] en,
                                            input logic [SEL_W-1:0]  cur);
    next_ch_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) begin
        r.found = 1'b1;
        r.ch    = SEL_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] lowest_enabled(input logic [NUM_CH-1:0] en);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux select/sample and frame handshake bundle.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] ch_en;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] frame;
  logic              frame_valid;
  logic              frame_ready;
  logic              busy;

  modport master (
    input  start, ch_en, mux_out, frame_ready,
    output sel, frame, frame_valid, busy
  );

  modport slave (
    output start, ch_en, mux_out, frame_ready,
    input  sel, frame, frame_valid, busy
  );

endinterface

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// Settle-time down-counter: reload on load, counts while en, done_c on the
// last settle cycle.
module scan_dwell_cnt #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE_CYC);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled channels of the 4:1 mux into a 4-bit frame with valid/ready
// hand-off. Define MUX_SCAN_CONT_EN for continuous back-to-back scanning.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.master bus
);

  scan_state_t       state, state_d;
  logic [NUM_CH-1:0] en_q, en_q_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              load_c;
  logic              dwell_done_c;
  next_ch_t          nxt_c;

  scan_dwell_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .en     (state == SETTLE),
    .done_c (dwell_done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      en_q    <= '0;
      sel_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      en_q    <= en_q_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output values; every output lands in a register.
  always_comb begin
    state_d = state;
    en_q_d  = en_q;
    sel_d   = sel_q;
    frame_d = frame_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    load_c  = 1'b0;
    nxt_c   = next_enabled(en_q, sel_q);

    case (state)
      IDLE: begin
        sel_d = '0;
        if (bus.start && (bus.ch_en != '0)) begin
          en_q_d  = bus.ch_en;
          frame_d = '0;
          sel_d   = lowest_enabled(bus.ch_en);
          load_c  = 1'b1;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (dwell_done_c) state_d = SAMPLE;
      end
      SAMPLE: begin
        frame_d[sel_q] = bus.mux_out;
        if (nxt_c.found) begin
          sel_d   = nxt_c.ch;
          load_c  = 1'b1;
          state_d = SETTLE;
        end else begin
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (valid_q && bus.frame_ready) begin
          valid_d = 1'b0;
`ifdef MUX_SCAN_CONT_EN
          // Restart on the latched mask without passing through IDLE.
          frame_d = '0;
          sel_d   = lowest_enabled(en_q);
          load_c  = 1'b1;
          state_d = SETTLE;
`else
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus pushes expected scans, a
// negedge monitor checks select walk, timing and frames against them.
module tb_mux_scan_ctrl;

  localparam int unsigned S = 2;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ip  = 4'b0000;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  bit   hs         = 1'b0;
  int   n          = 0;
  int   scan_len   = 0;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl #(
    .SETTLE_CYC(S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Ideal 4:1 mux driven by the controller's select.
  assign bus.mux_out = ip[bus.sel];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // j-th enabled channel of mask in ascending order.
  function automatic int nth_ch(input logic [3:0] m, input int j);
    int c;
    int r;
    c = 0;
    r = -1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (c == j && r < 0) r = i;
        c++;
      end
    end
    return r;
  endfunction

  // Monitor: one scan is k*(S+1) cycles of select walk, then DONE until ready.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      hs         = 1'b0;
    end else begin
      if (mon_active && hs) begin
        hs = 1'b0;
        chk("hs_valid_drop", 8'(bus.frame_valid), 8'd0);
`ifdef MUX_SCAN_CONT_EN
        chk("cont_busy", 8'(bus.busy), 8'd1);
        chk("cont_next_item", 8'(sb.size() != 0), 8'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          n   = 0;
        end else begin
          mon_active = 1'b0;
        end
`else
        chk("idle_busy", 8'(bus.busy), 8'd0);
        chk("idle_sel", 8'(bus.sel), 8'd0);
        chk("idle_frame_kept", 8'(bus.frame), 8'(cur.frame));
        mon_active = 1'b0;
`endif
      end else if (!mon_active && sb.size() != 0) begin
        cur        = sb.pop_front();
        n          = 0;
        mon_active = 1'b1;
      end
      if (mon_active) begin
        scan_len = $countones(cur.mask) * (S + 1);
        if (n < scan_len) begin
          chk("scan_sel", 8'(bus.sel), 8'(nth_ch(cur.mask, n / (S + 1))));
          chk("scan_valid_low", 8'(bus.frame_valid), 8'd0);
          chk("scan_busy", 8'(bus.busy), 8'd1);
          n++;
        end else begin
          chk("done_valid", 8'(bus.frame_valid), 8'd1);
          chk("done_frame", 8'(bus.frame), 8'(cur.frame));
          chk("done_sel", 8'(bus.sel), 8'(nth_ch(cur.mask, $countones(cur.mask) - 1)));
          if (bus.frame_ready) hs = 1'b1;
        end
      end
    end
  end

  task automatic run_scan(input logic [3:0] m, input logic [3:0] pi, input int d, input bit mid);
    exp_t e;
    int   len;
    ip              = pi;
    bus.frame_ready = (d == 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ch_en = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ch_en = 4'($urandom);
    e.mask    = m;
    e.frame   = m & pi;
    sb.push_back(e);
    len = $countones(m) * (S + 1);
    for (int c = 1; c <= len + d; c++) begin
      @(posedge clk); #1;
      bus.start = mid && (c == len / 2);
      bus.ch_en = 4'($urandom);
    end
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 8 && mon_active; i++) @(negedge clk);
    #1;
    chk("scan_complete", 8'(mon_active), 8'd0);
  endtask

  task automatic reset_mid(input logic [3:0] m, input logic [3:0] pi);
    exp_t e;
    ip              = pi;
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ch_en = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.mask    = m;
    e.frame   = m & pi;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_sel", 8'(bus.sel), 8'd0);
    chk("rstmid_frame", 8'(bus.frame), 8'd0);
    chk("rstmid_busy", 8'(bus.busy), 8'd0);
    chk("rstmid_valid", 8'(bus.frame_valid), 8'd0);
  endtask

  task automatic cont_test();
    exp_t       e;
    logic [3:0] pi;
    bus.frame_ready = 1'b1;
    ip              = 4'b1001;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ch_en = 4'b1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.mask    = 4'b1111;
    e.frame   = 4'b1001;
    sb.push_back(e);
    for (int j = 0; j < 5; j++) begin
      for (int c = 1; c <= 13; c++) begin
        @(posedge clk); #1;
        bus.start = (c == 5);
        bus.ch_en = 4'($urandom);
      end
      pi      = 4'($urandom);
      ip      = pi;
      e.frame = pi;
      sb.push_back(e);
    end
    repeat (12) @(posedge clk);
    #1 bus.frame_ready = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.ch_en       = 4'b0000;
    bus.frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_sel", 8'(bus.sel), 8'd0);
    chk("reset_frame", 8'(bus.frame), 8'd0);
    chk("reset_valid", 8'(bus.frame_valid), 8'd0);
    chk("reset_busy", 8'(bus.busy), 8'd0);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ch_en = 4'b0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("empty_mask_busy", 8'(bus.busy), 8'd0);
    @(posedge clk); #1;
    chk("empty_mask_sel", 8'(bus.sel), 8'd0);

`ifdef MUX_SCAN_CONT_EN
    cont_test();
`else
    run_scan(4'b1111, 4'b1001, 0, 1'b0);
    run_scan(4'b1010, 4'b0111, 0, 1'b0);
    run_scan(4'b1111, 4'b0110, 5, 1'b1);
    reset_mid(4'b1111, 4'b1011);
    run_scan(4'b1111, 4'b1100, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      run_scan(4'($urandom_range(1, 15)), 4'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
    end
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
